// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the seq_detector_n family.
//   state_t        - detector FSM states (IDLE, RUN)
//   clog2()        - ceil(log2(v)) for port/field sizing
//   SEQ_W_DEF      - default symbol width used by the lab benches
//   SEQ_DEPTH_DEF  - default pattern length used by the lab benches
package seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int SEQ_W_DEF     = 3;
    localparam int SEQ_DEPTH_DEF = 4;

    // Smallest r with 2**r >= v; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_detector_n_if.sv
// seq_detector_n_if: symbol stream into the detector and its hit pulse out.
//   in_valid - x carries a symbol this cycle (no back-pressure: the detector
//              always accepts; a symbol counts on every edge with in_valid=1)
//   x        - input symbol, W bits
//   y        - registered one-cycle hit pulse
// master = symbol source / hit consumer, slave = detector.
interface seq_detector_n_if
    import seq_pkg::*;
#(
    parameter int W = SEQ_W_DEF
);
    logic         in_valid;
    logic [W-1:0] x;
    logic         y;

    modport master (output in_valid, output x, input y);
    modport slave  (input in_valid, input x, output y);
endinterface

// File: rtl/sym_history.sv
// sym_history: DEPTH x W symbol shift register.
//   clk, rst   - clock, synchronous active-high reset (history -> 0)
//   clr_i      - clear history to 0 (wins over shift_i)
//   shift_i    - shift sym_i in as the newest symbol
//   sym_i      - incoming symbol
//   hist_o     - current history; symbol k (k=0 oldest) at [W*k +: W]
//   hist_nxt_o - history as it would be after shifting sym_i in
module sym_history #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic [W-1:0]       sym_i,
    output logic [W*DEPTH-1:0] hist_o,
    output logic [W*DEPTH-1:0] hist_nxt_o
);
    logic [W*DEPTH-1:0] hist_q, hist_d;

    // Newest symbol enters at the top; the oldest falls off bit 0.
    generate
        if (DEPTH == 1) begin : g_one
            assign hist_nxt_o = sym_i;
        end else begin : g_many
            assign hist_nxt_o = {sym_i, hist_q[W*DEPTH-1:W]};
        end
    endgenerate

    always_comb begin
        hist_d = hist_q;
        if (clr_i)        hist_d = '0;
        else if (shift_i) hist_d = hist_nxt_o;
    end

    always_ff @(posedge clk) begin
        if (rst) hist_q <= '0;
        else     hist_q <= hist_d;
    end

    assign hist_o = hist_q;
endmodule

// File: rtl/seq_detector_n.sv
// seq_detector_n: masked pattern detector over the last DEPTH symbols.
//   clk, rst      - clock, synchronous active-high reset
//   start, stop   - IDLE->RUN / RUN->IDLE pulses (stop wins)
//   cfg_we        - load cfg_pattern/cfg_mask (IDLE only; in RUN sets cfg_err)
//   cfg_pattern   - expected symbols, symbol k (0 = oldest) at [W*k +: W]
//   cfg_mask      - 1 = bit compared, 0 = don't care
//   cnt_clr       - clear hit_cnt (beats a same-cycle increment)
//   sif           - symbol stream in (in_valid, x), hit pulse out (y)
//   hit_cnt       - saturating hit count
//   running       - 1 while in RUN
//   fill          - symbols collected since last restart (0..DEPTH)
//   cfg_err       - sticky: cfg_we seen in RUN
//   state_o       - FSM state, for observation
//   hist_o        - current symbol history, for observation
module seq_detector_n
    import seq_pkg::*;
#(
    parameter int W       = SEQ_W_DEF,
    parameter int DEPTH   = SEQ_DEPTH_DEF,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        cfg_we,
    input  logic [W*DEPTH-1:0]          cfg_pattern,
    input  logic [W*DEPTH-1:0]          cfg_mask,
    input  logic                        cnt_clr,
    seq_detector_n_if.slave             sif,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic                        running,
    output logic [clog2(DEPTH+1)-1:0]   fill,
    output logic                        cfg_err,
    output state_t                      state_o,
    output logic [W*DEPTH-1:0]          hist_o
);
    localparam int FW = clog2(DEPTH + 1);
    localparam int PW = W * DEPTH;
    localparam logic [FW-1:0]    FILL_FULL = FW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic [PW-1:0]     pat_q, pat_d, mask_q, mask_d;
    logic [FW-1:0]     fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              y_q, y_d, err_q, err_d;
    logic              hist_clr, hist_shift, match;
    logic [PW-1:0]     hist_nxt;

    sym_history #(.W(W), .DEPTH(DEPTH)) u_hist (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (hist_clr),
        .shift_i    (hist_shift),
        .sym_i      (sif.x),
        .hist_o     (hist_o),
        .hist_nxt_o (hist_nxt)
    );

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        mask_d     = mask_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        hist_clr   = 1'b0;
        hist_shift = 1'b0;
        match      = 1'b0;
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    pat_d    = cfg_pattern;
                    mask_d   = cfg_mask;
                    hist_clr = 1'b1;
                    fill_d   = '0;
                end
                if (start && !stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_we) err_d = 1'b1;
                // A stop takes precedence over a symbol arriving in the same cycle.
                if (stop) begin
                    state_d = ST_IDLE;
                    fill_d  = '0;
                end else if (sif.in_valid) begin
                    hist_shift = 1'b1;
                    fill_d     = fill_inc;
                    match      = (fill_inc == FILL_FULL) &&
                                 (((hist_nxt ^ pat_q) & mask_q) == '0);
                    if (match && (OVERLAP == 0)) fill_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        y_d = match;
        if (cnt_clr)                        cnt_d = '0;
        else if (match && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            mask_q  <= '1;
            fill_q  <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign sif.y   = y_q;
    assign hit_cnt = cnt_q;
    assign running = (state_q == ST_RUN);
    assign fill    = fill_q;
    assign cfg_err = err_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_seq_detector_n.sv
// Three detectors (overlap, non-overlap, overlap with 3-bit counter) share one
// stimulus stream. The driver pushes the hit_cnt value expected alongside each
// y pulse; the monitor pops on every y pulse and compares.
module tb_seq_detector_n;
    import seq_pkg::*;

    localparam int W     = 3;
    localparam int DEPTH = 4;
    localparam int PW    = W * DEPTH;
    localparam int FW    = clog2(DEPTH + 1);

    localparam logic [PW-1:0] PAT_110  = 12'hDB6;  // 110 in every slot
    localparam logic [PW-1:0] MASK_ALL = 12'hFFF;
    localparam logic [PW-1:0] MASK_LO2 = 12'h6DB;  // 011 in every slot

    // ---------------- clock / reset / inputs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, cfg_we, cnt_clr, in_valid;
    logic [PW-1:0] cfg_pattern, cfg_mask;
    logic [W-1:0]  x;

    seq_detector_n_if #(.W(W)) if_ov ();
    seq_detector_n_if #(.W(W)) if_no ();
    seq_detector_n_if #(.W(W)) if_sat ();
    assign if_ov.in_valid  = in_valid;
    assign if_ov.x         = x;
    assign if_no.in_valid  = in_valid;
    assign if_no.x         = x;
    assign if_sat.in_valid = in_valid;
    assign if_sat.x        = x;

    logic [7:0]    cnt_ov, cnt_no;
    logic [2:0]    cnt_sat;
    logic [FW-1:0] fill_ov, fill_no, fill_sat;
    logic          run_ov, run_no, run_sat, err_ov, err_no, err_sat;
    state_t        st_ov, st_no, st_sat;
    logic [PW-1:0] hist_ov, hist_no, hist_sat;

    seq_detector_n #(.W(W), .DEPTH(DEPTH), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
        .sif(if_ov), .hit_cnt(cnt_ov), .running(run_ov), .fill(fill_ov),
        .cfg_err(err_ov), .state_o(st_ov), .hist_o(hist_ov));

    seq_detector_n #(.W(W), .DEPTH(DEPTH), .OVERLAP(0), .CNT_W(8)) u_no (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
        .sif(if_no), .hit_cnt(cnt_no), .running(run_no), .fill(fill_no),
        .cfg_err(err_no), .state_o(st_no), .hist_o(hist_no));

    seq_detector_n #(.W(W), .DEPTH(DEPTH), .OVERLAP(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
        .sif(if_sat), .hit_cnt(cnt_sat), .running(run_sat), .fill(fill_sat),
        .cfg_err(err_sat), .state_o(st_sat), .hist_o(hist_sat));

    // ---------------- scoreboard ----------------
    logic [7:0] exp_ov[$], exp_no[$], exp_sat[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic no_pulse_expected(input string name, input logic [31:0] cnt);
        n_checks++;
        $display("FAIL %s: y pulse with hit_cnt %0d, expected no pulse", name, cnt);
    endtask

    // Monitor: every y pulse must match the next queued hit_cnt value.
    always @(negedge clk) begin
        if (if_ov.y !== 1'b0) begin
            if (exp_ov.size() == 0) no_pulse_expected("ov_y", 32'(cnt_ov));
            else chk("ov_y_cnt", 32'(cnt_ov), 32'(exp_ov.pop_front()));
        end
        if (if_no.y !== 1'b0) begin
            if (exp_no.size() == 0) no_pulse_expected("no_y", 32'(cnt_no));
            else chk("no_y_cnt", 32'(cnt_no), 32'(exp_no.pop_front()));
        end
        if (if_sat.y !== 1'b0) begin
            if (exp_sat.size() == 0) no_pulse_expected("sat_y", 32'(cnt_sat));
            else chk("sat_y_cnt", 32'(cnt_sat), 32'(exp_sat.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        start    = 1'b0;
        stop     = 1'b0;
        cfg_we   = 1'b0;
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic sym(input logic [W-1:0] s);
        in_valid = 1'b1;
        x        = s;
        tick();
    endtask

    task automatic load(input logic [PW-1:0] p, input logic [PW-1:0] m);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_we      = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int ov, input int no, input int sat);
        if (ov  >= 0) exp_ov.push_back(8'(ov));
        if (no  >= 0) exp_no.push_back(8'(no));
        if (sat >= 0) exp_sat.push_back(8'(sat));
    endtask

    task automatic chk_cnt(input string tag, input int ov, input int no, input int sat);
        chk({tag, "_cnt_ov"},  32'(cnt_ov),  32'(ov));
        chk({tag, "_cnt_no"},  32'(cnt_no),  32'(no));
        chk({tag, "_cnt_sat"}, 32'(cnt_sat), 32'(sat));
    endtask

    task automatic chk_fill(input string tag, input int ov, input int no, input int sat);
        chk({tag, "_fill_ov"},  32'(fill_ov),  32'(ov));
        chk({tag, "_fill_no"},  32'(fill_no),  32'(no));
        chk({tag, "_fill_sat"}, 32'(fill_sat), 32'(sat));
    endtask

    // Stream of 110 symbols numbered first..last since the last restart.
    task automatic run_110(input int first, input int last, input logic [W-1:0] s);
        for (int n = first; n <= last; n++) begin
            push((n >= DEPTH) ? n - 3 : -1,
                 (n % DEPTH == 0) ? n / DEPTH : -1,
                 (n >= DEPTH) ? ((n - 3 > 7) ? 7 : n - 3) : -1);
            sym(s);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b0; x = '0; cfg_pattern = '0; cfg_mask = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_y",       32'(if_ov.y), 32'd0);
        chk("rst_running", 32'(run_ov),  32'd0);
        chk("rst_state",   32'(st_ov),   32'(ST_IDLE));
        chk("rst_cfg_err", 32'(err_ov),  32'd0);
        chk_cnt("rst", 0, 0, 0);
        chk_fill("rst", 0, 0, 0);

        // Overlap / non-overlap / saturation on a run of 110
        load(PAT_110, MASK_ALL);
        do_start();
        chk("start_running", 32'(run_ov), 32'd1);
        run_110(1, 10, 3'b110);
        chk_cnt("run10", 7, 2, 7);
        chk_fill("run10", 4, 2, 4);
        run_110(11, 15, 3'b110);
        chk_cnt("run15", 12, 3, 7);
        chk_fill("run15", 4, 3, 4);
        do_stop();
        chk("stop_running", 32'(run_ov), 32'd0);
        chk_fill("stop", 0, 0, 0);

        // Mismatch, then the same symbols with bit 2 masked off
        do_reset();
        load(PAT_110, MASK_ALL);
        do_start();
        for (int n = 0; n < 10; n++) sym(3'b010);
        chk_cnt("mismatch", 0, 0, 0);
        do_stop();
        load(PAT_110, MASK_LO2);
        do_start();
        run_110(1, 10, 3'b010);
        chk_cnt("masked", 7, 2, 7);
        do_stop();

        // Gaps do not break the sequence; stop beats a completing symbol
        do_reset();
        load(PAT_110, MASK_ALL);
        do_start();
        sym(3'b110);
        sym(3'b110);
        tick();
        tick();
        tick();
        sym(3'b110);
        push(1, 1, 1);
        sym(3'b110);
        chk_cnt("gap", 1, 1, 1);
        chk_fill("gap", 4, 0, 4);
        stop = 1'b1;
        sym(3'b110);
        chk_cnt("stop_hit", 1, 1, 1);
        chk_fill("stop_hit", 0, 0, 0);
        chk("stop_hit_running", 32'(run_ov), 32'd0);

        // cnt_clr on a match cycle wins over the increment
        do_reset();
        load(PAT_110, MASK_ALL);
        do_start();
        sym(3'b110);
        sym(3'b110);
        sym(3'b110);
        push(0, 0, 0);
        cnt_clr = 1'b1;
        sym(3'b110);
        chk_cnt("clr", 0, 0, 0);

        // cfg_we in RUN: ignored, sticky error
        load('0, MASK_ALL);
        chk("cfgerr_ov",  32'(err_ov),  32'd1);
        chk("cfgerr_no",  32'(err_no),  32'd1);
        chk("cfgerr_sat", 32'(err_sat), 32'd1);
        for (int n = 1; n <= 4; n++) begin
            push(n, (n == 4) ? 1 : -1, n);
            sym(3'b110);
        end
        chk_cnt("cfgerr_keep", 4, 1, 4);
        chk("cfgerr_sticky", 32'(err_ov), 32'd1);

        // Reset mid-run restores everything, including pattern 0 / mask all ones
        do_reset();
        chk("midrst_y",       32'(if_ov.y), 32'd0);
        chk("midrst_running", 32'(run_ov),  32'd0);
        chk("midrst_cfg_err", 32'(err_ov),  32'd0);
        chk("midrst_hist",    32'(hist_ov), 32'd0);
        chk_cnt("midrst", 0, 0, 0);
        chk_fill("midrst", 0, 0, 0);
        do_start();
        sym(3'b000);
        sym(3'b000);
        sym(3'b000);
        push(1, 1, 1);
        sym(3'b000);
        for (int n = 0; n < 4; n++) sym(3'b100);
        chk_cnt("rst_mask", 1, 1, 1);

        // Drain and make sure every expected pulse was seen
        tick();
        tick();
        tick();
        chk("left_ov",  32'(exp_ov.size()),  32'd0);
        chk("left_no",  32'(exp_no.size()),  32'd0);
        chk("left_sat", 32'(exp_sat.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
